// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU datapath: op select codes and
// the FSM state encoding used by serial_addsub.
package serial_alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full-adder slice for the serial add/subtract stage.
// inv=1 complements b so the same slice performs A + ~B + cin (subtract).
// Sum is formed by two cascaded two-input XOR cells; carry uses AND/OR.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic inv,
    output logic s,
    output logic co
);

    logic b_eff;
    logic p;

    // Conditional operand inversion, propagate term, then sum and carry.
    always_comb begin
        b_eff = b ^ inv;
        p     = a ^ b_eff;
        s     = p ^ cin;
        co    = (a & b_eff) | (cin & p);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract stage, LSB first, one bit per clk.
// Optional macro SERIAL_ADDSUB_OVF_EN adds the two's-complement overflow
// output ovf; without it the port and its register are absent.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; operands captured on the accepting edge
// ST_SHIFT | one result bit per edge, busy=1, WIDTH edges total
// ST_DONE  | done=1 for one cycle, result and flags stable
module serial_addsub
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             cout,
    output logic             zero
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             op_q;
    logic [CW-1:0]    count;
    logic             fa_s;
    logic             fa_co;

    serial_fa_bit u_fa (
        .a   (sa[0]),
        .b   (sb[0]),
        .cin (carry),
        .inv (op_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // New sum bit enters at the MSB so the result lines up after WIDTH shifts.
    assign res_next = {fa_s, res[WIDTH-1:1]};

    // Sequencer, operand/result shift registers and registered outputs.
    // Y is only updated on the final shift edge so the consumer never sees
    // a partially assembled result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            op_q  <= OP_ADD;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Y     <= '0;
            cout  <= 1'b0;
            zero  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        res   <= '0;
                        carry <= op;
                        op_q  <= op;
                        count <= '0;
                        busy  <= 1'b1;
                        Y     <= '0;
                        cout  <= 1'b0;
                        zero  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf   <= 1'b0;
`endif
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    res   <= res_next;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= fa_co;
                    if (count == LAST) begin
                        count <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Y     <= res_next;
                        cout  <= fa_co;
                        zero  <= (res_next == '0);
`ifdef SERIAL_ADDSUB_OVF_EN
                        // carry here is the carry into the MSB slice.
                        ovf   <= carry ^ fa_co;
`endif
                        state <= ST_DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=8). Stimulus pushes expected
// results; a monitor pops and compares whenever done is seen.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Y;
    logic       cout;
    logic       zero;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic       ovf;
`endif

    typedef struct packed {
        logic [7:0] y;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    serial_addsub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Y     (Y),
        .cout  (cout),
        .zero  (zero)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("sb_y", 32'(Y), 32'(e.y));
                chk("sb_cout", 32'(cout), 32'(e.c));
                chk("sb_zero", 32'(zero), 32'(e.z));
`ifdef SERIAL_ADDSUB_OVF_EN
                chk("sb_ovf", 32'(ovf), 32'(e.v));
`endif
            end
        end
    end

    // Issue one operation, check handshake timing; optionally poke start mid-op.
    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ey, input logic ec, input logic ez,
                          input logic ev, input bit poke);
        int lat;
        bit found;
        lat   = 0;
        found = 0;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        q.push_back('{y: ey, c: ec, z: ez, v: ev});
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("busy_cycle1", 32'(busy), 32'd1);
                chk("y_cleared_on_start", 32'(Y), 32'd0);
                start = 1'b0; op = ~o; A = ~a; B = ~b;
            end
            if (k == 8) chk("busy_cycle8", 32'(busy), 32'd1);
            if (done) begin
                found = 1;
                lat   = k;
                chk("busy_low_at_done", 32'(busy), 32'd0);
                break;
            end
            if (poke && k == 4) begin
                start = 1'b1; A = 8'hAA; B = 8'h55;
            end
            if (poke && k == 5) start = 1'b0;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=cycle9");
        end else begin
            chk("done_latency", 32'(lat), 32'd9);
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("y_hold", 32'(Y), 32'(ey));
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_y", 32'(Y), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0, 0);
        run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 0);
        run_op(1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
        run_op(1'b1, 8'h55, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0, 0);

        d0 = done_cnt;
        run_op(1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1);
        repeat (12) @(negedge clk);
        chk("single_done_after_poke", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of an operation: no done may follow.
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 8'h12; B = 8'h34;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_y", 32'(Y), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        run_op(1'b0, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 0);

        // Signed-overflow corners (ovf compared only when the feature exists).
        run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 0);
        run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 0);
        run_op(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
